// File: rtl/led_pkg.sv
// Shared definitions for the status LED arbiter: mode encodings and FSM states.
package led_pkg;

  // Per-source LED pattern request encoding.
  localparam logic [1:0] LED_OFF  = 2'd0;
  localparam logic [1:0] LED_ON   = 2'd1;
  localparam logic [1:0] LED_SLOW = 2'd2;
  localparam logic [1:0] LED_FAST = 2'd3;

  // Arbiter ownership states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OWN  = 2'd2
  } state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Base tick prescaler plus the free-running slow and fast blink phase dividers.
// The phases are never reset on owner changes, only by rst.
module led_tick_gen #(
  parameter int TICK_DIV   = 50_000,
  parameter int SLOW_TICKS = 250,
  parameter int FAST_TICKS = 62
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic slow_ph,
  output logic fast_ph
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SLOW_TICKS > 1) ? $clog2(SLOW_TICKS) : 1;
  localparam int FW = (FAST_TICKS > 1) ? $clog2(FAST_TICKS) : 1;

  logic [TW-1:0] div_cnt;
  logic [SW-1:0] slow_cnt;
  logic [FW-1:0] fast_cnt;

  // Tick is a single-cycle strobe at the prescaler's terminal count.
  assign tick = (div_cnt == TW'(TICK_DIV - 1));

  // Prescaler counts 0..TICK_DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + TW'(1);
    end
  end

  // Slow phase toggles on every SLOW_TICKS-th tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      slow_cnt <= '0;
      slow_ph  <= 1'b0;
    end else if (tick) begin
      if (slow_cnt == SW'(SLOW_TICKS - 1)) begin
        slow_cnt <= '0;
        slow_ph  <= ~slow_ph;
      end else begin
        slow_cnt <= slow_cnt + SW'(1);
      end
    end
  end

  // Fast phase toggles on every FAST_TICKS-th tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      fast_cnt <= '0;
      fast_ph  <= 1'b0;
    end else if (tick) begin
      if (fast_cnt == FW'(FAST_TICKS - 1)) begin
        fast_cnt <= '0;
        fast_ph  <= ~fast_ph;
      end else begin
        fast_cnt <= fast_cnt + FW'(1);
      end
    end
  end

endmodule

// File: rtl/led_status_arb.sv
// Fixed-priority arbiter sharing one status LED between NUM_REQ sources.
// A new owner is guaranteed HOLD_TICKS ticks before a higher source can
// preempt; the LED shows the owner's live mode pattern.
// Optional activity stretch (inverts the pattern after an act strobe) is
// enabled by defining LED_ACT_STRETCH_EN.
module led_status_arb
  import led_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TICK_DIV    = 50_000,
  parameter int SLOW_TICKS  = 250,
  parameter int FAST_TICKS  = 62,
  parameter int HOLD_TICKS  = 100,
  parameter int PULSE_TICKS = 50
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   mode,
  input  logic                   act,
  output logic                   led,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  state_t            state;
  logic [HW-1:0]     hold_cnt;
  logic              tick;
  logic              slow_ph;
  logic              fast_ph;
  logic [NUM_REQ-1:0] req_low;
  logic [NUM_REQ-1:0] higher;
  logic [NUM_REQ-1:0] higher_low;
  logic              owner_req;
  logic [1:0]        owner_mode;
  logic              pattern;
  logic              stretch;

  led_tick_gen #(
    .TICK_DIV   (TICK_DIV),
    .SLOW_TICKS (SLOW_TICKS),
    .FAST_TICKS (FAST_TICKS)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .slow_ph (slow_ph),
    .fast_ph (fast_ph)
  );

  // Lowest set bit isolates the highest-priority requester; grant-1 masks
  // every source strictly above the one-hot owner.
  assign req_low    = req & (~req + NUM_REQ'(1));
  assign higher     = req & (grant - NUM_REQ'(1));
  assign higher_low = higher & (~higher + NUM_REQ'(1));
  assign owner_req  = |(req & grant);

  // Select the current owner's live mode; zero when idle.
  always_comb begin
    owner_mode = LED_OFF;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) owner_mode = mode[2*i +: 2];
    end
  end

  // Translate the owner's mode into the raw pattern bit.
  always_comb begin
    pattern = 1'b0;
    case (owner_mode)
      LED_OFF:  pattern = 1'b0;
      LED_ON:   pattern = 1'b1;
      LED_SLOW: pattern = slow_ph;
      LED_FAST: pattern = fast_ph;
      default:  pattern = 1'b0;
    endcase
  end

  // Ownership FSM: release beats preemption, preemption beats the hold tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant    <= req_low;
            hold_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!owner_req) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (tick) begin
            if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
              state <= ST_OWN;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        ST_OWN: begin
          if (!owner_req) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (|higher) begin
            grant    <= higher_low;
            hold_cnt <= '0;
            state    <= ST_HOLD;
          end
        end
        default: begin
          grant    <= '0;
          busy     <= 1'b0;
          hold_cnt <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LED_ACT_STRETCH_EN
  localparam int PW = $clog2(PULSE_TICKS + 1);
  logic [PW-1:0] pulse_cnt;

  // Activity stretcher: act (ignored while idle) reloads, ticks drain it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_cnt <= '0;
    end else if (act && (state != ST_IDLE)) begin
      pulse_cnt <= PW'(PULSE_TICKS);
    end else if (tick && (pulse_cnt != '0)) begin
      pulse_cnt <= pulse_cnt - PW'(1);
    end
  end

  assign stretch = (pulse_cnt != '0);
`else
  localparam int unused_pulse_ticks = PULSE_TICKS;
  logic unused_act;
  assign unused_act = act;
  assign stretch    = 1'b0;
`endif

  // Registered LED drive; dark whenever nobody owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= 1'b0;
    end else begin
      led <= (state != ST_IDLE) & (pattern ^ stretch);
    end
  end

endmodule
